// File: rtl/traffic_timing_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_timing_ctrl_if : detector/light inputs and phase-time outputs      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface traffic_timing_ctrl_if;
   logic       veh_sense;
   logic       ped_req;
   logic       light_green;
   logic [5:0] red_time;
   logic [5:0] green_time;
   logic [7:0] veh_count;
   logic       ped_pending;
   logic       upd_pulse;
   logic       sec_tick;

   modport master (
      output veh_sense, ped_req, light_green,
      input  red_time, green_time, veh_count, ped_pending, upd_pulse, sec_tick
   );

   modport slave (
      input  veh_sense, ped_req, light_green,
      output red_time, green_time, veh_count, ped_pending, upd_pulse, sec_tick
   );
endinterface
`default_nettype wire

// File: rtl/traffic_timing_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_timing_ctrl : adaptive red/green phase times, vehicle counting,    |
// | pedestrian latch (TTC_PED_EN) and 1-second tick.        Rev 1.0            |
// +----------------------------------------------------------------------------+
module traffic_timing_ctrl #(
   parameter int CLK_PER_SEC = 100,
   parameter int DEBOUNCE    = 3,
   parameter int MIN_GREEN   = 10,
   parameter int MAX_GREEN   = 40,
   parameter int BASE_RED    = 20,
   parameter int PED_EXTRA   = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   traffic_timing_ctrl_if.slave bus
);

   localparam int PS_W = $clog2(CLK_PER_SEC);
   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
   localparam int PED_RED_I = (BASE_RED + PED_EXTRA > 63) ? 63 : (BASE_RED + PED_EXTRA);
   localparam logic [5:0] PED_RED = 6'(PED_RED_I);

   typedef enum logic [1:0] {
      WAIT_RED = 2'd0,
      MEASURE  = 2'd1,
      COMPUTE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
   logic            sec_tick_q, sec_tick_d;
   logic [1:0]      veh_sync_q, veh_sync_d;
   logic            veh_deb_q, veh_deb_d;
   logic [DB_W-1:0] veh_dbc_q, veh_dbc_d;
   logic            veh_evt;
   logic            prev_green_q, prev_green_d;
   logic            grn_rise;
   logic [7:0]      veh_count_q, veh_count_d;
   logic [5:0]      red_time_q, red_time_d;
   logic [5:0]      green_time_q, green_time_d;
   logic            upd_pulse_q, upd_pulse_d;
   logic [9:0]      green_sum;
   logic            ped_active;

   always_comb begin
      ps_cnt_d   = (ps_cnt_q == PS_LAST) ? '0 : ps_cnt_q + 1'b1;
      sec_tick_d = (ps_cnt_q == PS_LAST);
   end

   // veh_evt fires in the cycle whose edge flips the debounced level 0->1
   always_comb begin
      veh_sync_d = {veh_sync_q[0], bus.veh_sense};
      veh_deb_d  = veh_deb_q;
      veh_dbc_d  = '0;
      veh_evt    = 1'b0;
      if (veh_sync_q[1] != veh_deb_q) begin
         if (veh_dbc_q == DB_LAST) begin
            veh_deb_d = ~veh_deb_q;
            veh_evt   = ~veh_deb_q;
         end else begin
            veh_dbc_d = veh_dbc_q + 1'b1;
         end
      end
   end

   assign prev_green_d = bus.light_green;
   assign grn_rise     = bus.light_green & ~prev_green_q;

   always_comb begin
      state_d      = state_q;
      veh_count_d  = veh_count_q;
      red_time_d   = red_time_q;
      green_time_d = green_time_q;
      upd_pulse_d  = 1'b0;
      green_sum    = 10'(MIN_GREEN) + {1'b0, veh_count_q, 1'b0};
      case (state_q)
         WAIT_RED: begin
            if (!bus.light_green) begin
               state_d     = MEASURE;
               veh_count_d = '0;
            end
         end
         MEASURE: begin
            if (veh_evt && (veh_count_q != 8'hFF)) begin
               veh_count_d = veh_count_q + 1'b1;
            end
            if (grn_rise) begin
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            if (ped_active) begin
               green_time_d = 6'(MIN_GREEN);
               red_time_d   = PED_RED;
            end else begin
               green_time_d = (green_sum > 10'(MAX_GREEN)) ? 6'(MAX_GREEN) : green_sum[5:0];
               red_time_d   = 6'(BASE_RED);
            end
            upd_pulse_d = 1'b1;
            state_d     = WAIT_RED;
         end
         default: state_d = WAIT_RED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= WAIT_RED;
         ps_cnt_q     <= '0;
         sec_tick_q   <= 1'b0;
         veh_sync_q   <= '0;
         veh_deb_q    <= 1'b0;
         veh_dbc_q    <= '0;
         prev_green_q <= 1'b0;
         veh_count_q  <= '0;
         red_time_q   <= 6'(BASE_RED);
         green_time_q <= 6'(MIN_GREEN);
         upd_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ps_cnt_q     <= ps_cnt_d;
         sec_tick_q   <= sec_tick_d;
         veh_sync_q   <= veh_sync_d;
         veh_deb_q    <= veh_deb_d;
         veh_dbc_q    <= veh_dbc_d;
         prev_green_q <= prev_green_d;
         veh_count_q  <= veh_count_d;
         red_time_q   <= red_time_d;
         green_time_q <= green_time_d;
         upd_pulse_q  <= upd_pulse_d;
      end
   end

`ifdef TTC_PED_EN
   logic [1:0]      ped_sync_q, ped_sync_d;
   logic            ped_deb_q, ped_deb_d;
   logic [DB_W-1:0] ped_dbc_q, ped_dbc_d;
   logic            ped_evt;
   logic            ped_pending_q, ped_pending_d;

   // A new request in the COMPUTE cycle outlives the clear and is serviced next update
   always_comb begin
      ped_sync_d = {ped_sync_q[0], bus.ped_req};
      ped_deb_d  = ped_deb_q;
      ped_dbc_d  = '0;
      ped_evt    = 1'b0;
      if (ped_sync_q[1] != ped_deb_q) begin
         if (ped_dbc_q == DB_LAST) begin
            ped_deb_d = ~ped_deb_q;
            ped_evt   = ~ped_deb_q;
         end else begin
            ped_dbc_d = ped_dbc_q + 1'b1;
         end
      end
      ped_pending_d = ped_pending_q;
      if (state_q == COMPUTE) begin
         ped_pending_d = 1'b0;
      end
      if (ped_evt) begin
         ped_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ped_sync_q    <= '0;
         ped_deb_q     <= 1'b0;
         ped_dbc_q     <= '0;
         ped_pending_q <= 1'b0;
      end else begin
         ped_sync_q    <= ped_sync_d;
         ped_deb_q     <= ped_deb_d;
         ped_dbc_q     <= ped_dbc_d;
         ped_pending_q <= ped_pending_d;
      end
   end

   assign ped_active = ped_pending_q;
`else
   logic unused_ped_req;
   assign unused_ped_req = bus.ped_req;
   assign ped_active     = 1'b0;
`endif

   assign bus.red_time    = red_time_q;
   assign bus.green_time  = green_time_q;
   assign bus.veh_count   = veh_count_q;
   assign bus.ped_pending = ped_active;
   assign bus.upd_pulse   = upd_pulse_q;
   assign bus.sec_tick    = sec_tick_q;

endmodule
`default_nettype wire
